// File: rtl/bp_pkg.sv
// Shared definitions for the branch resolve controller.
//   BP_XLEN / BP_IDX_W : default address and predictor-index widths
//   bp_rec_t           : one in-flight prediction record as captured at FETCH
//   bp_state_e         : update-port scheduler states
//   bp_is_mispredict   : compares a recorded prediction with the EXEC outcome
package bp_pkg;

   localparam int BP_XLEN  = 32;
   localparam int BP_IDX_W = 2;

   typedef struct packed {
      logic [BP_XLEN-1:0]  pc;
      logic                hit;
      logic [BP_IDX_W-1:0] idx;
      logic                pred_taken;
      logic [BP_XLEN-1:0]  pred_target;
   } bp_rec_t;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_UPD  = 1'b1
   } bp_state_e;

   // The predicted target only matters when the branch was actually taken.
   function automatic logic bp_is_mispredict(input bp_rec_t rec,
                                             input logic taken,
                                             input logic [BP_XLEN-1:0] target);
      return (rec.pred_taken != taken) || (taken && (rec.pred_target != target));
   endfunction

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// Bundle of every non-clock signal of branch_resolve_ctrl.
//   slave  : the controller side (takes fetch/exec/ready inputs, drives the rest)
//   master : the environment side (fetch unit, EXEC unit, predictor)
// Fetch group  : f_push, f_pc, f_hit, f_idx, f_pred_taken, f_pred_target, q_full
// Exec group   : x_resolve, x_taken, x_target, x_stall
// Redirect     : redirect_valid, redirect_pc, flush
// Table update : upd_valid, upd_alloc, upd_idx, upd_pc, upd_target, upd_taken, upd_ready
// Status       : err_underflow
interface branch_resolve_ctrl_if
   import bp_pkg::*;
#(
   parameter int XLEN  = BP_XLEN,
   parameter int IDX_W = BP_IDX_W
) ();

   logic             f_push;
   logic [XLEN-1:0]  f_pc;
   logic             f_hit;
   logic [IDX_W-1:0] f_idx;
   logic             f_pred_taken;
   logic [XLEN-1:0]  f_pred_target;
   logic             q_full;

   logic             x_resolve;
   logic             x_taken;
   logic [XLEN-1:0]  x_target;
   logic             x_stall;

   logic             redirect_valid;
   logic [XLEN-1:0]  redirect_pc;
   logic             flush;

   logic             upd_valid;
   logic             upd_alloc;
   logic [IDX_W-1:0] upd_idx;
   logic [XLEN-1:0]  upd_pc;
   logic [XLEN-1:0]  upd_target;
   logic             upd_taken;
   logic             upd_ready;

   logic             err_underflow;

   modport slave (
      input  f_push, f_pc, f_hit, f_idx, f_pred_taken, f_pred_target,
      input  x_resolve, x_taken, x_target,
      input  upd_ready,
      output q_full, x_stall,
      output redirect_valid, redirect_pc, flush,
      output upd_valid, upd_alloc, upd_idx, upd_pc, upd_target, upd_taken,
      output err_underflow
   );

   modport master (
      output f_push, f_pc, f_hit, f_idx, f_pred_taken, f_pred_target,
      output x_resolve, x_taken, x_target,
      output upd_ready,
      input  q_full, x_stall,
      input  redirect_valid, redirect_pc, flush,
      input  upd_valid, upd_alloc, upd_idx, upd_pc, upd_target, upd_taken,
      input  err_underflow
   );

endinterface

// File: rtl/bp_pred_fifo.sv
// Show-ahead FIFO of in-flight prediction records.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_push     : write i_rec (ignored when full without a same-cycle pop)
//   i_pop      : drop the head record
//   i_flush    : discard all contents; overrides push and pop
//   i_rec      : record to write
//   o_head     : oldest record, valid whenever !o_empty
//   o_empty    : no records held
//   o_full     : DEPTH records held
module bp_pred_fifo
   import bp_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic    clk,
   input  logic    rst_n,
   input  logic    i_push,
   input  logic    i_pop,
   input  logic    i_flush,
   input  bp_rec_t i_rec,
   output bp_rec_t o_head,
   output logic    o_empty,
   output logic    o_full
);

   localparam int             PTR_W    = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   bp_rec_t          r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;

   logic w_do_pop;
   logic w_do_push;

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == FULL_CNT);
   // Head must be visible in the resolve cycle, so the read is combinational.
   assign o_head  = r_mem[r_rd_ptr];

   assign w_do_pop  = i_pop && !i_flush && !o_empty;
   // A full queue can still take a record when the head leaves this cycle.
   assign w_do_push = i_push && !i_flush && (!o_full || w_do_pop);

   // Storage carries no reset; pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_rec;
      end
   end

   // Pointers are exactly PTR_W bits wide, so increments wrap modulo DEPTH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolve controller: queues FETCH-stage predictions, matches them in
// order with EXEC outcomes, raises redirect/flush on a mispredict and
// schedules the predictor's single table write port.
//   clk    : clock, all state on the rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : branch_resolve_ctrl_if.slave (fetch, exec, redirect, update, status)
// Record widths come from bp_pkg; XLEN/IDX_W must match the package values.
module branch_resolve_ctrl
   import bp_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int IDX_W = BP_IDX_W,
   parameter int XLEN  = BP_XLEN
) (
   input logic                  clk,
   input logic                  rst_n,
   branch_resolve_ctrl_if.slave bus
);

   if ((XLEN != BP_XLEN) || (IDX_W != BP_IDX_W) ||
       (DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_cfg
      $error("branch_resolve_ctrl: unsupported DEPTH/XLEN/IDX_W combination");
   end

   bp_rec_t   w_head;
   bp_rec_t   w_push_rec;
   logic      w_empty;
   logic      w_full;
   logic      w_x_stall;
   logic      w_res_acc;
   logic      w_underflow;
   logic      w_mispredict;
   logic      w_push_acc;
   logic [XLEN-1:0] w_redirect_pc;
   bp_state_e w_state_next;

   bp_state_e        r_state;
   logic             r_redirect;
   logic [XLEN-1:0]  r_redirect_pc;
   logic             r_flush;
   logic             r_upd_alloc;
   logic [IDX_W-1:0] r_upd_idx;
   logic [XLEN-1:0]  r_upd_pc;
   logic [XLEN-1:0]  r_upd_target;
   logic             r_upd_taken;
   logic             r_err;

   // ------------------------------------------------------------------
   // Handshake decode
   // ------------------------------------------------------------------
   // The update register is single-entry: a new resolve may only land when
   // the pending write is being taken this very cycle.
   assign w_x_stall    = (r_state == ST_UPD) && !bus.upd_ready;
   assign w_res_acc    = bus.x_resolve && !w_x_stall && !w_empty;
   assign w_underflow  = bus.x_resolve && !w_x_stall && w_empty;
   assign w_mispredict = w_res_acc && bp_is_mispredict(w_head, bus.x_taken, bus.x_target);

   // Records pushed while a mispredict resolves, or while the flush pulse is
   // out, come from the wrong path and are dropped.
   assign w_push_acc = bus.f_push && !w_mispredict && !r_flush &&
                       (!w_full || w_res_acc);

   // Fall-through address wraps naturally at XLEN bits.
   assign w_redirect_pc = bus.x_taken ? bus.x_target : (w_head.pc + XLEN'(4));

   always_comb begin
      w_push_rec             = '0;
      w_push_rec.pc          = bus.f_pc;
      w_push_rec.hit         = bus.f_hit;
      w_push_rec.idx         = bus.f_idx;
      w_push_rec.pred_taken  = bus.f_pred_taken;
      w_push_rec.pred_target = bus.f_pred_target;
   end

   // ------------------------------------------------------------------
   // In-flight queue; a mispredict clears everything younger at once.
   // ------------------------------------------------------------------
   bp_pred_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push_acc),
      .i_pop   (w_res_acc),
      .i_flush (w_mispredict),
      .i_rec   (w_push_rec),
      .o_head  (w_head),
      .o_empty (w_empty),
      .o_full  (w_full)
   );

   // ------------------------------------------------------------------
   // Update-port scheduler
   // ------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_res_acc) begin
               w_state_next = ST_UPD;
            end
         end
         ST_UPD: begin
            // Stay busy when the write retires and another resolve reloads.
            if (bus.upd_ready && !w_res_acc) begin
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_upd_alloc  <= 1'b0;
         r_upd_idx    <= '0;
         r_upd_pc     <= '0;
         r_upd_target <= '0;
         r_upd_taken  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         // Accepted resolves only occur when the register is free or
         // retiring, so loading here never disturbs a held request.
         if (w_res_acc) begin
            r_upd_alloc  <= !w_head.hit;
            r_upd_idx    <= w_head.idx;
            r_upd_pc     <= w_head.pc;
            r_upd_target <= bus.x_target;
            r_upd_taken  <= bus.x_taken;
         end
      end
   end

   // ------------------------------------------------------------------
   // Redirect / flush pulse and sticky error
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_redirect    <= 1'b0;
         r_redirect_pc <= '0;
         r_flush       <= 1'b0;
         r_err         <= 1'b0;
      end else begin
         r_redirect <= w_mispredict;
         r_flush    <= w_mispredict;
         if (w_mispredict) begin
            r_redirect_pc <= w_redirect_pc;
         end
         if (w_underflow) begin
            r_err <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign bus.q_full         = w_full;
   assign bus.x_stall        = w_x_stall;
   assign bus.redirect_valid = r_redirect;
   assign bus.redirect_pc    = r_redirect_pc;
   assign bus.flush          = r_flush;
   assign bus.upd_valid      = (r_state == ST_UPD);
   assign bus.upd_alloc      = r_upd_alloc;
   assign bus.upd_idx        = r_upd_idx;
   assign bus.upd_pc         = r_upd_pc;
   assign bus.upd_target     = r_upd_target;
   assign bus.upd_taken      = r_upd_taken;
   assign bus.err_underflow  = r_err;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed, table-driven bench for branch_resolve_ctrl.
module tb_branch_resolve_ctrl;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   branch_resolve_ctrl_if #(.XLEN(32), .IDX_W(2)) bus ();

   branch_resolve_ctrl #(
      .DEPTH (4),
      .IDX_W (2),
      .XLEN  (32)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic push, input logic [31:0] pc, input logic hit,
                        input logic [1:0] idx, input logic ptk, input logic [31:0] ptgt,
                        input logic res, input logic xtk, input logic [31:0] xtgt,
                        input logic rdy);
      bus.f_push        = push;
      bus.f_pc          = pc;
      bus.f_hit         = hit;
      bus.f_idx         = idx;
      bus.f_pred_taken  = ptk;
      bus.f_pred_target = ptgt;
      bus.x_resolve     = res;
      bus.x_taken       = xtk;
      bus.x_target      = xtgt;
      bus.upd_ready     = rdy;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".q_full"},         32'(bus.q_full),         32'h0);
      chk({tag, ".x_stall"},        32'(bus.x_stall),        32'h0);
      chk({tag, ".redirect_valid"}, 32'(bus.redirect_valid), 32'h0);
      chk({tag, ".redirect_pc"},    bus.redirect_pc,         32'h0);
      chk({tag, ".flush"},          32'(bus.flush),          32'h0);
      chk({tag, ".upd_valid"},      32'(bus.upd_valid),      32'h0);
      chk({tag, ".upd_alloc"},      32'(bus.upd_alloc),      32'h0);
      chk({tag, ".upd_idx"},        32'(bus.upd_idx),        32'h0);
      chk({tag, ".upd_pc"},         bus.upd_pc,              32'h0);
      chk({tag, ".upd_target"},     bus.upd_target,          32'h0);
      chk({tag, ".upd_taken"},      32'(bus.upd_taken),      32'h0);
      chk({tag, ".err_underflow"},  32'(bus.err_underflow),  32'h0);
   endtask

   // One vector = inputs for one cycle, pre-edge combinational expectations,
   // and the registered outputs expected just after the edge.
   typedef struct {
      logic        push;
      logic [31:0] pc;
      logic        hit;
      logic [1:0]  idx;
      logic        ptk;
      logic [31:0] ptgt;
      logic        res;
      logic        xtk;
      logic [31:0] xtgt;
      logic        rdy;
      logic        e_stall;
      logic        e_full_pre;
      logic        e_redir;
      logic [31:0] e_rpc;
      logic        e_uv;
      logic        e_alloc;
      logic [1:0]  e_idx;
      logic [31:0] e_upc;
      logic [31:0] e_utgt;
      logic        e_utk;
      logic        e_full;
   } vec_t;

   localparam int NV = 23;
   vec_t vt [NV];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //       push pc       hit idx ptk ptgt      res xtk xtgt      rdy  stl fpre redir rpc      uv alc idx upc      utgt     utk full
      // 1: hit, correct prediction
      vt[0]  = '{1, 32'h40,  1, 1, 1, 32'h80,     0, 0, 32'h0,   1,   0, 0,   0, 32'h0,    0, 0, 0, 32'h0,   32'h0,   0, 0};
      vt[1]  = '{0, 32'h0,   0, 0, 0, 32'h0,      1, 1, 32'h80,  1,   0, 0,   0, 32'h0,    1, 0, 1, 32'h40,  32'h80,  1, 0};
      // 2: miss predicted NT, actually taken
      vt[2]  = '{1, 32'h100, 0, 3, 0, 32'h0,      0, 0, 32'h0,   1,   0, 0,   0, 32'h0,    0, 0, 0, 32'h0,   32'h0,   0, 0};
      vt[3]  = '{0, 32'h0,   0, 0, 0, 32'h0,      1, 1, 32'h200, 1,   0, 0,   1, 32'h200,  1, 1, 3, 32'h100, 32'h200, 1, 0};
      vt[4]  = '{0, 32'h0,   0, 0, 0, 32'h0,      0, 0, 32'h0,   1,   0, 0,   0, 32'h0,    0, 0, 0, 32'h0,   32'h0,   0, 0};
      // 3: two in flight, older mispredicts NT; pushes in resolve and flush cycles dropped
      vt[5]  = '{1, 32'h10,  1, 2, 1, 32'h30,     0, 0, 32'h0,   1,   0, 0,   0, 32'h0,    0, 0, 0, 32'h0,   32'h0,   0, 0};
      vt[6]  = '{1, 32'h30,  1, 0, 0, 32'h0,      0, 0, 32'h0,   1,   0, 0,   0, 32'h0,    0, 0, 0, 32'h0,   32'h0,   0, 0};
      vt[7]  = '{1, 32'h50,  1, 0, 0, 32'h0,      1, 0, 32'h34,  1,   0, 0,   1, 32'h14,   1, 0, 2, 32'h10,  32'h34,  0, 0};
      vt[8]  = '{1, 32'h60,  1, 0, 0, 32'h0,      0, 0, 32'h0,   1,   0, 0,   0, 32'h0,    0, 0, 0, 32'h0,   32'h0,   0, 0};
      // 4: fill from empty (full exactly after the 4th), 5th ignored, pop+push while full
      vt[9]  = '{1, 32'h200, 1, 1, 1, 32'h300,    0, 0, 32'h0,   1,   0, 0,   0, 32'h0,    0, 0, 0, 32'h0,   32'h0,   0, 0};
      vt[10] = '{1, 32'h210, 1, 2, 0, 32'h0,      0, 0, 32'h0,   1,   0, 0,   0, 32'h0,    0, 0, 0, 32'h0,   32'h0,   0, 0};
      vt[11] = '{1, 32'h220, 0, 0, 1, 32'h400,    0, 0, 32'h0,   1,   0, 0,   0, 32'h0,    0, 0, 0, 32'h0,   32'h0,   0, 0};
      vt[12] = '{1, 32'h230, 1, 3, 1, 32'h500,    0, 0, 32'h0,   1,   0, 0,   0, 32'h0,    0, 0, 0, 32'h0,   32'h0,   0, 1};
      vt[13] = '{1, 32'h240, 1, 1, 1, 32'h600,    0, 0, 32'h0,   1,   0, 1,   0, 32'h0,    0, 0, 0, 32'h0,   32'h0,   0, 1};
      vt[14] = '{1, 32'h250, 1, 0, 0, 32'h0,      1, 1, 32'h300, 1,   0, 1,   0, 32'h0,    1, 0, 1, 32'h200, 32'h300, 1, 1};
      // 5: back-to-back update, then upd_ready low 3 cycles with a waiting resolve
      vt[15] = '{0, 32'h0,   0, 0, 0, 32'h0,      1, 0, 32'h0,   1,   0, 1,   0, 32'h0,    1, 0, 2, 32'h210, 32'h0,   0, 0};
      vt[16] = '{0, 32'h0,   0, 0, 0, 32'h0,      1, 1, 32'h400, 0,   1, 0,   0, 32'h0,    1, 0, 2, 32'h210, 32'h0,   0, 0};
      vt[17] = '{0, 32'h0,   0, 0, 0, 32'h0,      1, 1, 32'h400, 0,   1, 0,   0, 32'h0,    1, 0, 2, 32'h210, 32'h0,   0, 0};
      vt[18] = '{0, 32'h0,   0, 0, 0, 32'h0,      1, 1, 32'h400, 0,   1, 0,   0, 32'h0,    1, 0, 2, 32'h210, 32'h0,   0, 0};
      vt[19] = '{0, 32'h0,   0, 0, 0, 32'h0,      1, 1, 32'h400, 1,   0, 0,   0, 32'h0,    1, 1, 0, 32'h220, 32'h400, 1, 0};
      vt[20] = '{0, 32'h0,   0, 0, 0, 32'h0,      0, 0, 32'h0,   1,   0, 0,   0, 32'h0,    0, 0, 0, 32'h0,   32'h0,   0, 0};
      // direction right but target wrong
      vt[21] = '{0, 32'h0,   0, 0, 0, 32'h0,      1, 1, 32'h504, 1,   0, 0,   1, 32'h504,  1, 0, 3, 32'h230, 32'h504, 1, 0};
      vt[22] = '{0, 32'h0,   0, 0, 0, 32'h0,      0, 0, 32'h0,   1,   0, 0,   0, 32'h0,    0, 0, 0, 32'h0,   32'h0,   0, 0};

      // ---------------- reset state ----------------
      drive(0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0);
      #2 rst_n = 1'b0;
      step();
      step();
      chk_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk(("post_reset.upd_valid"), 32'(bus.upd_valid), 32'h0);
      chk(("post_reset.redirect"),  32'(bus.redirect_valid), 32'h0);

      // ---------------- table ----------------
      for (int i = 0; i < NV; i++) begin
         drive(vt[i].push, vt[i].pc, vt[i].hit, vt[i].idx, vt[i].ptk, vt[i].ptgt,
               vt[i].res, vt[i].xtk, vt[i].xtgt, vt[i].rdy);
         #1;
         chk($sformatf("v%0d.x_stall", i), 32'(bus.x_stall), 32'(vt[i].e_stall));
         chk($sformatf("v%0d.q_full_pre", i), 32'(bus.q_full), 32'(vt[i].e_full_pre));
         step();
         $display("vec %0d: push=%0b pc=0x%0h res=%0b rdy=%0b -> redir=%0b rpc=0x%0h uv=%0b upc=0x%0h full=%0b",
                  i, vt[i].push, vt[i].pc, vt[i].res, vt[i].rdy, bus.redirect_valid,
                  bus.redirect_pc, bus.upd_valid, bus.upd_pc, bus.q_full);
         chk($sformatf("v%0d.redirect_valid", i), 32'(bus.redirect_valid), 32'(vt[i].e_redir));
         chk($sformatf("v%0d.flush", i), 32'(bus.flush), 32'(vt[i].e_redir));
         if (vt[i].e_redir)
            chk($sformatf("v%0d.redirect_pc", i), bus.redirect_pc, vt[i].e_rpc);
         chk($sformatf("v%0d.upd_valid", i), 32'(bus.upd_valid), 32'(vt[i].e_uv));
         if (vt[i].e_uv) begin
            chk($sformatf("v%0d.upd_alloc", i), 32'(bus.upd_alloc), 32'(vt[i].e_alloc));
            chk($sformatf("v%0d.upd_idx", i), 32'(bus.upd_idx), 32'(vt[i].e_idx));
            chk($sformatf("v%0d.upd_pc", i), bus.upd_pc, vt[i].e_upc);
            chk($sformatf("v%0d.upd_target", i), bus.upd_target, vt[i].e_utgt);
            chk($sformatf("v%0d.upd_taken", i), 32'(bus.upd_taken), 32'(vt[i].e_utk));
         end
         chk($sformatf("v%0d.q_full", i), 32'(bus.q_full), 32'(vt[i].e_full));
         chk($sformatf("v%0d.err_underflow", i), 32'(bus.err_underflow), 32'h0);
      end

      // ---------------- 6: resolve on empty (0x250 was flushed) ----------------
      drive(0, 32'h0, 0, 0, 0, 32'h0, 1, 1, 32'h700, 1);
      step();
      $display("underflow: err=%0b uv=%0b redir=%0b", bus.err_underflow, bus.upd_valid, bus.redirect_valid);
      chk("underflow.err_underflow", 32'(bus.err_underflow), 32'h1);
      chk("underflow.upd_valid", 32'(bus.upd_valid), 32'h0);
      chk("underflow.redirect_valid", 32'(bus.redirect_valid), 32'h0);

      // fall-through address wrap: pc=0xFFFFFFFC predicted T, actually NT
      drive(1, 32'hFFFF_FFFC, 1, 1, 1, 32'h100, 0, 0, 32'h0, 1);
      step();
      drive(0, 32'h0, 0, 0, 0, 32'h0, 1, 0, 32'h0, 1);
      step();
      drive(0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0);
      $display("wrap: redir=%0b rpc=0x%0h uv=%0b upc=0x%0h err=%0b",
               bus.redirect_valid, bus.redirect_pc, bus.upd_valid, bus.upd_pc, bus.err_underflow);
      chk("wrap.redirect_valid", 32'(bus.redirect_valid), 32'h1);
      chk("wrap.redirect_pc", bus.redirect_pc, 32'h0);
      chk("wrap.upd_valid", 32'(bus.upd_valid), 32'h1);
      chk("wrap.upd_pc", bus.upd_pc, 32'hFFFF_FFFC);
      chk("sticky.err_underflow", 32'(bus.err_underflow), 32'h1);
      #1;
      chk("hold.x_stall", 32'(bus.x_stall), 32'h1);

      // asynchronous reset mid-update, away from any clock edge
      #1 rst_n = 1'b0;
      #1;
      $display("async reset: redir=%0b uv=%0b stall=%0b err=%0b", bus.redirect_valid,
               bus.upd_valid, bus.x_stall, bus.err_underflow);
      chk_all_zero("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      drive(0, 32'h0, 0, 0, 0, 32'h0, 1, 1, 32'h0, 1);
      step();
      // queue was discarded by reset, so this resolve underflows again
      chk("after_rst.upd_valid", 32'(bus.upd_valid), 32'h0);
      chk("after_rst.err_underflow", 32'(bus.err_underflow), 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
